// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the timer0 interrupt controller: register map,
// flag bit positions and the request FSM state type.
package timer_irq_ctrl_pkg;

  localparam logic [7:0] ADDR_TIFR0  = 8'h15;
  localparam logic [7:0] ADDR_TIMSK0 = 8'h6E;

  localparam int BIT_TOV0  = 0;
  localparam int BIT_OCF0A = 1;
  localparam int BIT_OCF0B = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Register bus between the CPU (master) and the timer interrupt controller.
interface timer_irq_ctrl_if;
  logic       write;
  logic       read;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output write, read, addr, wdata, input rdata);
  modport slave  (input write, read, addr, wdata, output rdata);
endinterface

// File: rtl/timer_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: OCF0A > OCF0B > TOV0. Returns whether any source
// is pending, the vector of the winner and a one-hot grant of the winner.
module irq_prio_enc
  import timer_irq_ctrl_pkg::*;
#(
  parameter logic [4:0] VEC_COMPA = 5'd14,
  parameter logic [4:0] VEC_COMPB = 5'd15,
  parameter logic [4:0] VEC_OVF   = 5'd16
) (
  input  logic [2:0] pending,
  output logic       valid,
  output logic [4:0] vector,
  output logic [2:0] grant
);

  // Pick the highest-priority pending source.
  always_comb begin
    valid  = 1'b0;
    vector = 5'd0;
    grant  = 3'b000;
    if (pending[BIT_OCF0A]) begin
      valid            = 1'b1;
      vector           = VEC_COMPA;
      grant[BIT_OCF0A] = 1'b1;
    end else if (pending[BIT_OCF0B]) begin
      valid            = 1'b1;
      vector           = VEC_COMPB;
      grant[BIT_OCF0B] = 1'b1;
    end else if (pending[BIT_TOV0]) begin
      valid           = 1'b1;
      vector          = VEC_OVF;
      grant[BIT_TOV0] = 1'b1;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer0 interrupt controller: owns TIFR0/TIMSK0, arbitrates pending
// sources and runs the request/acknowledge handshake with the CPU.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter logic [4:0] VEC_COMPA = 5'd14,
  parameter logic [4:0] VEC_COMPB = 5'd15,
  parameter logic [4:0] VEC_OVF   = 5'd16
) (
  input  logic                   clk,
  input  logic                   rst,
  timer_irq_ctrl_if.slave        bus,
  input  logic                   tov_set,
  input  logic                   ocfa_set,
  input  logic                   ocfb_set,
  input  logic                   status_reg_interrupt_enable,
  output logic                   interrupt_request,
  output logic [4:0]             interrupt_vector,
  input  logic                   interrupt_executed
);

  irq_state_e state_q, state_d;
  logic [2:0] tifr_q, tifr_d;
  logic [2:0] timsk_q, timsk_d;
  logic [7:0] rdata_q, rdata_d;
  logic [4:0] vec_q, vec_d;
  logic [2:0] src_q, src_d;

  logic [2:0] pending;
  logic       enc_valid;
  logic [4:0] enc_vector;
  logic [2:0] enc_grant;
  logic [2:0] set_mask;
  logic       src_pending;
  logic       ack_take;
  logic       take_new;
  logic       unused_wdata;

  assign pending     = tifr_q & timsk_q;
  assign src_pending = |(src_q & pending);
  assign ack_take    = (state_q == ST_REQ) && interrupt_executed;
  assign take_new    = (state_q == ST_IDLE) && enc_valid && status_reg_interrupt_enable;
  assign unused_wdata = ^bus.wdata[7:3];

  assign set_mask[BIT_TOV0]  = tov_set;
  assign set_mask[BIT_OCF0A] = ocfa_set;
  assign set_mask[BIT_OCF0B] = ocfb_set;

  irq_prio_enc #(
    .VEC_COMPA (VEC_COMPA),
    .VEC_COMPB (VEC_COMPB),
    .VEC_OVF   (VEC_OVF)
  ) u_prio (
    .pending (pending),
    .valid   (enc_valid),
    .vector  (enc_vector),
    .grant   (enc_grant)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: an ack beats withdrawal because the CPU has already
  // taken the vector (and typically clears I in the same cycle).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take_new) state_d = ST_REQ;
      ST_REQ: begin
        if (interrupt_executed)                              state_d = ST_DONE;
        else if (!src_pending || !status_reg_interrupt_enable) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the vector is only visible while the request is high.
  always_comb begin
    interrupt_request = (state_q == ST_REQ);
    interrupt_vector  = (state_q == ST_REQ) ? vec_q : 5'd0;
  end

  // Latch the winning source when a request starts; frozen while in REQ.
  always_comb begin
    vec_d = vec_q;
    src_d = src_q;
    if (take_new) begin
      vec_d = enc_vector;
      src_d = enc_grant;
    end
  end

  // Flag and mask updates: clears first, then set strobes so a set wins.
  always_comb begin
    tifr_d  = tifr_q;
    timsk_d = timsk_q;
    if (bus.write && (bus.addr == ADDR_TIFR0))  tifr_d = tifr_d & ~bus.wdata[2:0];
    if (ack_take)                               tifr_d = tifr_d & ~src_q;
    tifr_d = tifr_d | set_mask;
    if (bus.write && (bus.addr == ADDR_TIMSK0)) timsk_d = bus.wdata[2:0];
  end

  // Registered read data; holds its value between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.read) begin
      case (bus.addr)
        ADDR_TIFR0:  rdata_d = {5'd0, tifr_q};
        ADDR_TIMSK0: rdata_d = {5'd0, timsk_q};
        default:     rdata_d = 8'h00;
      endcase
    end
  end

  // Register file, latched source and read data storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tifr_q  <= 3'b000;
      timsk_q <= 3'b000;
      rdata_q <= 8'h00;
      vec_q   <= 5'd0;
      src_q   <= 3'b000;
    end else begin
      tifr_q  <= tifr_d;
      timsk_q <= timsk_d;
      rdata_q <= rdata_d;
      vec_q   <= vec_d;
      src_q   <= src_d;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench for timer_irq_ctrl: a behavioural model predicts the
// outputs after every clock edge, a monitor compares them one edge later.
module tb_timer_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tov_set = 1'b0, ocfa_set = 1'b0, ocfb_set = 1'b0;
  logic       ie = 1'b0;
  logic       interrupt_request;
  logic [4:0] interrupt_vector;
  logic       interrupt_executed = 1'b0;

  timer_irq_ctrl_if bus_if ();

  timer_irq_ctrl dut (
    .clk                         (clk),
    .rst                         (rst),
    .bus                         (bus_if),
    .tov_set                     (tov_set),
    .ocfa_set                    (ocfa_set),
    .ocfb_set                    (ocfb_set),
    .status_reg_interrupt_enable (ie),
    .interrupt_request           (interrupt_request),
    .interrupt_vector            (interrupt_vector),
    .interrupt_executed          (interrupt_executed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [4:0] vec;
    logic [7:0] rd;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Model: index 0 = overflow, 1 = compare A, 2 = compare B.
  bit         m_flag[3];
  bit         m_mask[3];
  logic [7:0] m_rd;
  int         m_serving;   // source currently requested, -1 if none
  bit         m_cool;      // one forced quiet edge after an acknowledge
  int         prio[3] = '{1, 2, 0};
  bit         rst_next;
  bit         ie_g;

  function automatic logic [4:0] vec_of(input int s);
    case (s)
      0:       return 5'd16;
      1:       return 5'd14;
      default: return 5'd15;
    endcase
  endfunction

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    if (a == 8'h15) return {5'd0, m_flag[2], m_flag[1], m_flag[0]};
    if (a == 8'h6E) return {5'd0, m_mask[2], m_mask[1], m_mask[0]};
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_flag[k] = 1'b0;
      m_mask[k] = 1'b0;
    end
    m_rd      = 8'h00;
    m_serving = -1;
    m_cool    = 1'b0;
  endtask

  task automatic model_step(input bit s_t, s_a, s_b, i_en, ack, wr,
                            input logic [7:0] a, d, input bit rd);
    bit         nf[3];
    int         ns;
    bit         nc;
    logic [7:0] nrd;
    nrd = rd ? m_reg(a) : m_rd;
    nf  = m_flag;
    ns  = m_serving;
    nc  = m_cool;
    if (m_serving >= 0) begin
      if (ack) begin
        nf[m_serving] = 1'b0;
        ns = -1;
        nc = 1'b1;
      end else if (!(m_flag[m_serving] && m_mask[m_serving] && i_en)) begin
        ns = -1;
      end
    end else if (m_cool) begin
      nc = 1'b0;
    end else if (i_en) begin
      for (int k = 0; k < 3; k++)
        if (ns < 0 && m_flag[prio[k]] && m_mask[prio[k]]) ns = prio[k];
    end
    if (wr && a == 8'h15)
      for (int k = 0; k < 3; k++) if (d[k]) nf[k] = 1'b0;
    if (wr && a == 8'h6E)
      for (int k = 0; k < 3; k++) m_mask[k] = d[k];
    if (s_t) nf[0] = 1'b1;
    if (s_a) nf[1] = 1'b1;
    if (s_b) nf[2] = 1'b1;
    m_flag    = nf;
    m_serving = ns;
    m_cool    = nc;
    m_rd      = nrd;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.req = (m_serving >= 0);
    e.vec = e.req ? vec_of(m_serving) : 5'd0;
    e.rd  = m_rd;
    expq.push_back(e);
  endtask

  // Drive one cycle of stimulus at the falling edge and predict the next edge.
  task automatic cyc(input bit t, a_, b, i_en, ack, wr,
                     input logic [7:0] ad, wd, input bit rd);
    @(negedge clk);
    rst                = rst_next;
    tov_set            = t;
    ocfa_set           = a_;
    ocfb_set           = b;
    ie                 = i_en;
    interrupt_executed = ack;
    bus_if.write       = wr;
    bus_if.addr        = ad;
    bus_if.wdata       = wd;
    bus_if.read        = rd;
    if (!rst_next) model_reset();
    else model_step(t, a_, b, i_en, ack, wr, ad, wd, rd);
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, ie_g, 0, 0, 8'h00, 8'h00, 0);
  endtask
  task automatic pulse(input bit t, a_, b);
    cyc(t, a_, b, ie_g, 0, 0, 8'h00, 8'h00, 0);
  endtask
  task automatic ack_cyc();
    cyc(0, 0, 0, ie_g, 1, 0, 8'h00, 8'h00, 0);
  endtask
  task automatic wr_reg(input logic [7:0] a, d);
    cyc(0, 0, 0, ie_g, 0, 1, a, d, 0);
  endtask
  task automatic rd_reg(input logic [7:0] a);
    cyc(0, 0, 0, ie_g, 0, 0, a, 8'h00, 1);
  endtask

  // Assert reset between edges and confirm the request drops at once.
  task automatic reset_now();
    exp_t e;
    @(negedge clk);
    rst                = 1'b0;
    tov_set            = 1'b0;
    ocfa_set           = 1'b0;
    ocfb_set           = 1'b0;
    interrupt_executed = 1'b0;
    bus_if.write       = 1'b0;
    bus_if.read        = 1'b0;
    #1;
    chk("async_rst_req", {7'd0, interrupt_request}, 8'h00);
    chk("async_rst_vec", {3'd0, interrupt_vector}, 8'h00);
    model_reset();
    e.req = 1'b0;
    e.vec = 5'd0;
    e.rd  = 8'h00;
    expq.push_back(e);
  endtask

  // Monitor: compare DUT outputs just after each edge with the prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("irq_req", {7'd0, interrupt_request}, {7'd0, e.req});
        chk("irq_vec", {3'd0, interrupt_vector}, {3'd0, e.vec});
        chk("rdata", bus_if.rdata, e.rd);
      end
    end
  end

  initial begin
    bus_if.write = 1'b0;
    bus_if.read  = 1'b0;
    bus_if.addr  = 8'h00;
    bus_if.wdata = 8'h00;
    model_reset();
    ie_g     = 1'b1;
    rst_next = 1'b0;
    idle(3);
    rst_next = 1'b1;
    idle(2);

    // Single compare-B request, acknowledged.
    wr_reg(8'h6E, 8'h07);
    pulse(0, 0, 1);
    idle(2);
    ack_cyc();
    rd_reg(8'h15);
    idle(3);

    // Simultaneous overflow and compare-A: A first, overflow after.
    pulse(1, 1, 0);
    idle(2);
    ack_cyc();
    idle(3);
    ack_cyc();
    idle(2);

    // Masked source only shows in the flag register; write-1 clears it.
    wr_reg(8'h6E, 8'h00);
    pulse(0, 1, 0);
    idle(2);
    rd_reg(8'h15);
    idle(1);
    wr_reg(8'h15, 8'h02);
    rd_reg(8'h15);
    idle(1);

    // Withdrawal on I low, re-request on I high.
    wr_reg(8'h6E, 8'h07);
    pulse(1, 0, 0);
    idle(2);
    ie_g = 1'b0;
    idle(2);
    rd_reg(8'h15);
    ie_g = 1'b1;
    idle(3);
    ack_cyc();
    idle(2);

    // Set strobe colliding with the acknowledge of the same source.
    pulse(0, 1, 0);
    idle(2);
    cyc(0, 1, 0, ie_g, 1, 0, 8'h00, 8'h00, 0);
    idle(4);
    ack_cyc();
    idle(2);

    // Clearing the latched flag by a bus write while requesting.
    pulse(0, 0, 1);
    idle(2);
    wr_reg(8'h15, 8'h04);
    idle(3);

    // Reset in the middle of a request.
    pulse(0, 0, 1);
    idle(2);
    reset_now();
    rst_next = 1'b0;
    idle(1);
    rst_next = 1'b1;
    rd_reg(8'h15);
    rd_reg(8'h6E);
    rd_reg(8'h33);
    pulse(0, 1, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit         t, a_, b, i_en, ack, wr, rd;
      logic [7:0] ad, wd;
      int         sel;
      t    = ($urandom_range(0, 11) == 0);
      a_   = ($urandom_range(0, 11) == 0);
      b    = ($urandom_range(0, 11) == 0);
      i_en = ($urandom_range(0, 9) != 0);
      ack  = ($urandom_range(0, 3) == 0);
      wr   = ($urandom_range(0, 7) == 0);
      rd   = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 2);
      ad   = (sel == 0) ? 8'h15 : (sel == 1) ? 8'h6E : 8'($urandom);
      wd   = 8'($urandom);
      cyc(t, a_, b, i_en, ack, wr, ad, wd, rd);
    end
    idle(2);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
